// File: rtl/instruction_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Assembles a little-endian byte stream into instruction words
//               and writes them to instruction memory until HALT is seen.
//               Optional RECV inactivity timeout under macro LOADER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_loader #(
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 64,
  parameter logic [WORD_SIZE_IN_BYTES*8-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF,
  parameter int TIMEOUT_CYCLES     = 1_000_000
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset,
  input  logic                                   i_start,
  input  logic                                   i_byte_valid,
  input  logic [7:0]                             i_byte,
  output logic                                   o_byte_ready,
  input  logic                                   i_mem_full,
  output logic                                   o_clear,
  output logic                                   o_instruction_write,
  output logic [WORD_SIZE_IN_BYTES*8-1:0]        o_instruction,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic                                   o_error,
  output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0] o_word_count
);

  localparam int c_WORD_W = WORD_SIZE_IN_BYTES * 8;
  localparam int c_CNT_W  = $clog2(MEM_SIZE_IN_WORDS + 1);
  localparam int c_BYTE_W = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
  localparam logic [c_BYTE_W-1:0] c_LAST_BYTE = c_BYTE_W'(WORD_SIZE_IN_BYTES - 1);
  localparam logic [c_CNT_W-1:0]  c_LAST_WORD = c_CNT_W'(MEM_SIZE_IN_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RECV  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [c_WORD_W-1:0]   instr_q, instr_d;
  logic [c_CNT_W-1:0]    count_q, count_d;
  logic [c_BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic                  w_accept;

`ifdef LOADER_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LIMIT = c_TMO_W'(TIMEOUT_CYCLES);
  logic [c_TMO_W-1:0]    tmo_q, tmo_d;
`else
  // Timeout logic is absent; the parameter is only referenced at elaboration.
  if (TIMEOUT_CYCLES > 0) begin : g_no_timeout
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      count_q    <= '0;
      byte_cnt_q <= '0;
`ifdef LOADER_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      count_q    <= count_d;
      byte_cnt_q <= byte_cnt_d;
`ifdef LOADER_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign w_accept = (state_q == S_RECV) && i_byte_valid;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
`ifdef LOADER_TIMEOUT_EN
    // Held at zero outside RECV, so it restarts on every entry to RECV.
    tmo_d      = '0;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          state_d    = S_CLEAR;
          instr_d    = '0;
          count_d    = '0;
          byte_cnt_d = '0;
        end
      end
      S_CLEAR: begin
        state_d    = S_RECV;
        count_d    = '0;
        byte_cnt_d = '0;
      end
      S_RECV: begin
        if (w_accept) begin
          instr_d[int'(byte_cnt_q)*8 +: 8] = i_byte;
          if (byte_cnt_q == c_LAST_BYTE) begin
            state_d = S_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + c_BYTE_W'(1);
          end
        end
`ifdef LOADER_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + c_TMO_W'(1);
          if (tmo_d == c_TMO_LIMIT) begin
            state_d = S_ERROR;
          end
        end
`endif
      end
      S_WRITE: begin
        if (i_mem_full) begin
          state_d = S_ERROR;
        end else begin
          count_d = count_q + c_CNT_W'(1);
          // A non-HALT word filling the last slot leaves no room for HALT.
          if (instr_q == HALT_INSTRUCTION) begin
            state_d = S_DONE;
          end else if (count_q == c_LAST_WORD) begin
            state_d = S_ERROR;
          end else begin
            state_d    = S_RECV;
            byte_cnt_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_byte_ready        = (state_q == S_RECV);
  assign o_clear             = (state_q == S_CLEAR);
  assign o_instruction_write = (state_q == S_WRITE) && !i_mem_full;
  assign o_instruction       = instr_q;
  assign o_word_count        = count_q;
  assign o_busy              = (state_q == S_CLEAR) || (state_q == S_RECV) || (state_q == S_WRITE);
  assign o_done              = (state_q == S_DONE);
  assign o_error             = (state_q == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instruction_loader
// Description : Randomised and directed bench for instruction_loader, with a
//               session-level reference model (64-word and 4-word instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, valid, full;
  logic [7:0]  byt;

  logic        a_rdy, a_clr, a_wr, a_busy, a_done, a_err;
  logic [31:0] a_ins;
  logic [6:0]  a_cnt;
  logic        b_rdy, b_clr, b_wr, b_busy, b_done, b_err;
  logic [31:0] b_ins;
  logic [2:0]  b_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [31:0] wq[$];
  int a_clr_cnt, b_wr_cnt;
  int waits[16];

  always #5 clk = ~clk;

  instruction_loader #(.MEM_SIZE_IN_WORDS(64), .TIMEOUT_CYCLES(10)) dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_byte_valid(valid),
    .i_byte(byt), .o_byte_ready(a_rdy), .i_mem_full(full), .o_clear(a_clr),
    .o_instruction_write(a_wr), .o_instruction(a_ins), .o_busy(a_busy),
    .o_done(a_done), .o_error(a_err), .o_word_count(a_cnt));

  instruction_loader #(.MEM_SIZE_IN_WORDS(4), .TIMEOUT_CYCLES(10)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_byte_valid(valid),
    .i_byte(byt), .o_byte_ready(b_rdy), .i_mem_full(full), .o_clear(b_clr),
    .o_instruction_write(b_wr), .o_instruction(b_ins), .o_busy(b_busy),
    .o_done(b_done), .o_error(b_err), .o_word_count(b_cnt));

  // Session phases of the reference model.
  localparam int P_IDLE = 0, P_CLEAR = 1, P_RECV = 2, P_WRITE = 3, P_DONE = 4, P_ERROR = 5;

  typedef struct {
    int          phase;
    int          nbytes;
    logic [31:0] word;
    int          count;
    int          idle;
  } model_t;

  model_t ma, mb;

  function automatic model_t step(model_t m, int cap, logic rn, logic st,
                                  logic v, logic [7:0] b, logic f);
    model_t r = m;
    if (!rn) begin
      r.phase = P_IDLE; r.nbytes = 0; r.word = '0; r.count = 0; r.idle = 0;
      return r;
    end
    case (m.phase)
      P_IDLE, P_DONE, P_ERROR:
        if (st) begin
          r.phase = P_CLEAR; r.nbytes = 0; r.word = '0; r.count = 0;
        end
      P_CLEAR: begin
        r.phase = P_RECV; r.idle = 0;
      end
      P_RECV:
        if (v) begin
          r.word[8*m.nbytes +: 8] = b;
          r.nbytes = m.nbytes + 1;
          r.idle = 0;
          if (r.nbytes == 4) r.phase = P_WRITE;
        end else begin
          r.idle = m.idle + 1;
`ifdef LOADER_TIMEOUT_EN
          if (r.idle == 10) r.phase = P_ERROR;
`endif
        end
      P_WRITE:
        if (f) r.phase = P_ERROR;
        else begin
          r.count = m.count + 1;
          if (m.word == 32'hFFFF_FFFF) r.phase = P_DONE;
          else if (r.count == cap) r.phase = P_ERROR;
          else begin
            r.phase = P_RECV; r.nbytes = 0; r.idle = 0;
          end
        end
      default: r.phase = P_IDLE;
    endcase
    return r;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic cmp(string n, model_t m, logic rdy, logic clr, logic wr,
                     logic busy, logic done, logic err, logic [31:0] cnt,
                     logic [31:0] ins);
    check({n, ".ready"}, 32'(rdy), 32'(m.phase == P_RECV));
    check({n, ".clear"}, 32'(clr), 32'(m.phase == P_CLEAR));
    check({n, ".write"}, 32'(wr),  32'(m.phase == P_WRITE && !full));
    check({n, ".busy"},  32'(busy), 32'(m.phase >= P_CLEAR && m.phase <= P_WRITE));
    check({n, ".done"},  32'(done), 32'(m.phase == P_DONE));
    check({n, ".error"}, 32'(err),  32'(m.phase == P_ERROR));
    check({n, ".count"}, cnt, 32'(m.count));
    check({n, ".instr"}, ins, m.word);
    check({n, ".clr_wr_excl"}, 32'(clr & wr), 32'd0);
  endtask

  always @(posedge clk) begin
    ma <= step(ma, 64, rst_n, start, valid, byt, full);
    mb <= step(mb, 4,  rst_n, start, valid, byt, full);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("A", ma, a_rdy, a_clr, a_wr, a_busy, a_done, a_err, 32'(a_cnt), a_ins);
      cmp("B", mb, b_rdy, b_clr, b_wr, b_busy, b_done, b_err, 32'(b_cnt), b_ins);
      if (a_wr) wq.push_back(a_ins);
      if (a_clr) a_clr_cnt++;
      if (b_wr) b_wr_cnt++;
    end
  end

  task automatic clear_obs();
    wq.delete();
    a_clr_cnt = 0;
    b_wr_cnt  = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, output int w);
    bit ok = 1'b0;
    valid = 1'b1;
    byt   = b;
    w     = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_rdy) begin
        ok = 1'b1;
        break;
      end
      w++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout t=%0t got=no_ready expected=ready", $time);
    end
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] prog1 [8];
    logic [7:0] prog4 [4];
    int w;
    prog1 = '{8'h13, 8'h00, 8'h00, 8'h20, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    prog4 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; full = 1'b0; byt = 8'h00;
    clear_obs();
    @(posedge clk);
    #1 cmp_en = 1'b1;
    idle(1);
    rst_n = 1'b1;
    check("reset.busy",  32'(a_busy), 32'd0);
    check("reset.count", 32'(a_cnt),  32'd0);
    check("reset.instr", a_ins,       32'd0);

    // Two-word program ending in HALT.
    clear_obs();
    pulse_start();
    for (int i = 0; i < 8; i++) send(prog1[i], w);
    idle(3);
    check("p1.nwrites", 32'(wq.size()), 32'd2);
    check("p1.word0",   (wq.size() > 0) ? wq[0] : 32'hX, 32'h2000_0013);
    check("p1.word1",   (wq.size() > 1) ? wq[1] : 32'hX, 32'hFFFF_FFFF);
    check("p1.clears",  32'(a_clr_cnt), 32'd1);
    check("p1.done",    32'(a_done), 32'd1);
    check("p1.count",   32'(a_cnt),  32'd2);

    // Back-to-back bytes; the 4-word instance overflows.
    clear_obs();
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      send(8'(i + 1), w);
      waits[i] = w;
    end
    idle(3);
    for (int i = 0; i < 16; i++)
      check($sformatf("stream.wait%0d", i), 32'(waits[i]), 32'((i % 4) == 0));
    check("stream.nwrites", 32'(wq.size()), 32'd4);
    check("stream.word3",   (wq.size() > 3) ? wq[3] : 32'hX, 32'h100F_0E0D);
    check("small.writes",   32'(b_wr_cnt), 32'd4);
    check("small.error",    32'(b_err), 32'd1);
    check("small.count",    32'(b_cnt), 32'd4);

    // Memory full on the first write.
    do_reset();
    clear_obs();
    full = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) send(8'h55, w);
    idle(3);
    full = 1'b0;
    check("full.nwrites", 32'(wq.size()), 32'd0);
    check("full.error",   32'(a_err), 32'd1);
    check("full.count",   32'(a_cnt), 32'd0);

    // Reset in the middle of a word, then restart.
    clear_obs();
    pulse_start();
    send(8'h11, w);
    send(8'h22, w);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("midrst.busy",  32'(a_busy), 32'd0);
    check("midrst.instr", a_ins, 32'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) send(prog4[i], w);
    idle(3);
    check("restart.nwrites", 32'(wq.size()), 32'd1);
    check("restart.word",    (wq.size() > 0) ? wq[0] : 32'hX, 32'hDDCC_BBAA);

`ifdef LOADER_TIMEOUT_EN
    begin
      int n = 0;
      do_reset();
      pulse_start();
      send(8'h01, w);
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (a_err) begin
          n = k;
          break;
        end
      end
      check("timeout.cycles", 32'(n), 32'd11);
      idle(1);
    end
`endif

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      start = ($urandom_range(0, 19) == 0);
      valid = ($urandom_range(0, 9) < 7);
      byt   = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      full  = ($urandom_range(0, 29) == 0);
      idle(1);
    end
    rst_n = 1'b1; start = 1'b0; valid = 1'b0; full = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
